// File: rtl/sprite_motion_ctrl.sv
// Sprite position controller: synchronizes/debounces four direction keys and
// steps a clamped sprite position once per frame on the rising edge of vsync.

module key_debounce #(
  parameter logic [15:0] DB_COUNT = 16'd50000,
  parameter int          CW       = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic db
);
  localparam logic [CW-1:0] LAST = CW'(DB_COUNT - 16'd1);

  logic [1:0]    sync;  // [0]=s1, [1]=s2
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync <= '0;
      cnt  <= '0;
      db   <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      if (sync[1] == db)
        cnt <= '0;
      else if (cnt == LAST) begin
        db  <= sync[1];
        cnt <= '0;
      end else
        cnt <= cnt + CW'(1);
    end
  end
endmodule

module sprite_motion_ctrl #(
  parameter logic [15:0] DB_COUNT = 16'd50000,
  parameter int          POS_W    = 9,
  parameter int          X_MIN    = 0,
  parameter int          X_MAX    = 240,
  parameter int          Y_MIN    = 0,
  parameter int          Y_MAX    = 224,
  parameter int          X_INIT   = 120,
  parameter int          Y_INIT   = 112,
  parameter int          STEP     = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       keys,
  input  logic             vsync,
  output logic [POS_W-1:0] sprite_x,
  output logic [POS_W-1:0] sprite_y,
  output logic [3:0]       keys_db,
  output logic             frame_tick
);
  localparam int CW = $clog2(int'(DB_COUNT) + 1);
  localparam logic [POS_W:0] XLO = (POS_W+1)'(X_MIN);
  localparam logic [POS_W:0] XHI = (POS_W+1)'(X_MAX);
  localparam logic [POS_W:0] YLO = (POS_W+1)'(Y_MIN);
  localparam logic [POS_W:0] YHI = (POS_W+1)'(Y_MAX);
  localparam logic [POS_W:0] STP = (POS_W+1)'(STEP);

  for (genvar i = 0; i < 4; i++) begin : g_key
    key_debounce #(.DB_COUNT(DB_COUNT), .CW(CW)) u_db (
      .clk   (clk),
      .reset (reset),
      .raw   (keys[i]),
      .db    (keys_db[i])
    );
  end

  // [0]=s1, [1]=s2, [2]=previous s2 for rising-edge detect
  logic [2:0]       vs_pipe;
  logic [POS_W:0]   x_e, y_e;
  logic [POS_W-1:0] x_nxt, y_nxt;

  // One extra bit keeps the bound tests free of wrap-around at either end.
  always_comb begin
    x_e   = {1'b0, sprite_x};
    y_e   = {1'b0, sprite_y};
    x_nxt = sprite_x;
    y_nxt = sprite_y;
    if (keys_db[0] && !keys_db[1])
      x_nxt = (x_e >= XLO + STP) ? POS_W'(x_e - STP) : POS_W'(XLO);
    else if (keys_db[1] && !keys_db[0])
      x_nxt = (x_e + STP <= XHI) ? POS_W'(x_e + STP) : POS_W'(XHI);
    if (keys_db[2] && !keys_db[3])
      y_nxt = (y_e >= YLO + STP) ? POS_W'(y_e - STP) : POS_W'(YLO);
    else if (keys_db[3] && !keys_db[2])
      y_nxt = (y_e + STP <= YHI) ? POS_W'(y_e + STP) : POS_W'(YHI);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vs_pipe    <= '0;
      frame_tick <= 1'b0;
      sprite_x   <= POS_W'(X_INIT);
      sprite_y   <= POS_W'(Y_INIT);
    end else begin
      vs_pipe    <= {vs_pipe[1:0], vsync};
      frame_tick <= vs_pipe[1] & ~vs_pipe[2];
      if (frame_tick) begin
        sprite_x <= x_nxt;
        sprite_y <= y_nxt;
      end
    end
  end
endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Bench for sprite_motion_ctrl: per-cycle comparison against a history-window
// reference model plus directed checks of latency, cancel, glitch and clamping.

module tb_sprite_motion_ctrl;
  localparam int DB = 4;
  localparam int PW = 9;

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    keys;
  logic          vsync;
  logic [PW-1:0] sprite_x, sprite_y;
  logic [3:0]    keys_db;
  logic          frame_tick;

  int n_cmp = 0;
  int n_err = 0;

  sprite_motion_ctrl #(.DB_COUNT(16'd4)) dut (
    .clk        (clk),
    .reset      (reset),
    .keys       (keys),
    .vsync      (vsync),
    .sprite_x   (sprite_x),
    .sprite_y   (sprite_y),
    .keys_db    (keys_db),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  // Reference: kh[k]/vh[k] hold the raw inputs sampled k+1 edges ago.
  // A debounced bit flips once the raw key (two edges late through the
  // synchronizer) has shown the opposite value for DB consecutive samples;
  // a tick follows a 0->1 of vsync seen two samples late.
  logic [3:0]    kh [0:DB];
  logic          vh [0:2];
  logic [PW-1:0] rx, ry;
  logic [3:0]    rdb;
  logic          rt;

  always @(posedge clk) begin
    int nx, ny;
    logic [3:0] ndb;
    bit all_opp;
    if (reset) begin
      rx = PW'(120); ry = PW'(112); rdb = '0; rt = 1'b0;
      for (int k = 0; k <= DB; k++) kh[k] = '0;
      for (int k = 0; k < 3; k++) vh[k] = 1'b0;
    end else begin
      nx = int'(rx); ny = int'(ry);
      if (rt) begin
        if (rdb[0] && !rdb[1]) nx = (nx - 1 < 0)   ? 0   : nx - 1;
        if (rdb[1] && !rdb[0]) nx = (nx + 1 > 240) ? 240 : nx + 1;
        if (rdb[2] && !rdb[3]) ny = (ny - 1 < 0)   ? 0   : ny - 1;
        if (rdb[3] && !rdb[2]) ny = (ny + 1 > 224) ? 224 : ny + 1;
      end
      ndb = rdb;
      for (int b = 0; b < 4; b++) begin
        all_opp = 1'b1;
        for (int k = 1; k <= DB; k++)
          if (kh[k][b] == rdb[b]) all_opp = 1'b0;
        if (all_opp) ndb[b] = ~rdb[b];
      end
      rt = vh[1] & ~vh[2];
      for (int k = DB; k > 0; k--) kh[k] = kh[k-1];
      kh[0] = keys;
      vh[2] = vh[1]; vh[1] = vh[0]; vh[0] = vsync;
      rx = PW'(nx); ry = PW'(ny); rdb = ndb;
    end
  end

  task automatic test_reset();
    reset = 1'b1; keys = '0; vsync = 1'b0;
    for (int i = 0; i < 22; i++) begin
      reset = (i < 2);
      @(negedge clk);
      n_cmp++;
      if ({sprite_x, sprite_y, keys_db, frame_tick} !== {rx, ry, rdb, rt}) begin
        n_err++;
        $display("FAIL reset_model i=%0d got %0d/%0d/%b/%b want %0d/%0d/%b/%b",
                 i, sprite_x, sprite_y, keys_db, frame_tick, rx, ry, rdb, rt);
      end
      n_cmp++;
      if ({sprite_x, sprite_y, keys_db, frame_tick} !== {PW'(120), PW'(112), 4'b0, 1'b0}) begin
        n_err++;
        $display("FAIL reset_state i=%0d got %0d/%0d/%b/%b want 120/112/0000/0",
                 i, sprite_x, sprite_y, keys_db, frame_tick);
      end
    end
  endtask

  task automatic test_move_right();
    int first_db, ticks, tick_p;
    first_db = -1;
    for (int i = 0; i < 500; i++) begin
      int p;
      p = i % 100;
      keys = 4'b0010;
      vsync = (p >= 10 && p < 20);
      @(negedge clk);
      n_cmp++;
      if ({sprite_x, sprite_y, keys_db, frame_tick} !== {rx, ry, rdb, rt}) begin
        n_err++;
        $display("FAIL right_model i=%0d got %0d/%0d/%b/%b want %0d/%0d/%b/%b",
                 i, sprite_x, sprite_y, keys_db, frame_tick, rx, ry, rdb, rt);
      end
      if (keys_db[1] === 1'b1 && first_db < 0) first_db = i;
      if (p == 0) begin ticks = 0; tick_p = -1; end
      if (frame_tick === 1'b1) begin ticks++; tick_p = p; end
      if (p == 99) begin
        n_cmp++;
        if (ticks != 1 || tick_p != 12) begin
          n_err++;
          $display("FAIL right_tick frame=%0d got %0d ticks at p=%0d want 1 at p=12",
                   i / 100, ticks, tick_p);
        end
        n_cmp++;
        if (sprite_x !== PW'(121 + i / 100) || sprite_y !== PW'(112)) begin
          n_err++;
          $display("FAIL right_pos frame=%0d got %0d/%0d want %0d/112",
                   i / 100, sprite_x, sprite_y, 121 + i / 100);
        end
      end
    end
    n_cmp++;
    if (first_db + 1 != 6) begin
      n_err++;
      $display("FAIL right_db_latency got %0d edges want 6", first_db + 1);
    end
  endtask

  task automatic test_cancel();
    int w;
    for (int i = 0; i < 240; i++) begin
      int p;
      p = i % 40;
      if (p == 0) w = $urandom_range(1, 10);
      keys = (i < 120) ? 4'b0011 : 4'b1100;
      vsync = (p >= 10 && p < 10 + w);
      @(negedge clk);
      n_cmp++;
      if ({sprite_x, sprite_y, keys_db, frame_tick} !== {rx, ry, rdb, rt}) begin
        n_err++;
        $display("FAIL cancel_model i=%0d got %0d/%0d/%b/%b want %0d/%0d/%b/%b",
                 i, sprite_x, sprite_y, keys_db, frame_tick, rx, ry, rdb, rt);
      end
    end
    n_cmp++;
    if (sprite_x !== PW'(125) || sprite_y !== PW'(112)) begin
      n_err++;
      $display("FAIL cancel_pos got %0d/%0d want 125/112", sprite_x, sprite_y);
    end
  endtask

  task automatic test_glitch();
    for (int g = 0; g < 10; g++) begin
      int len;
      len = (g == 9) ? 0 : $urandom_range(1, 3);
      for (int i = 0; i < 10 + len; i++) begin
        keys = (i >= 10) ? 4'b0001 : 4'b0000;
        vsync = (i >= 2 && i < 4);
        @(negedge clk);
        n_cmp++;
        if ({sprite_x, sprite_y, keys_db, frame_tick} !== {rx, ry, rdb, rt}) begin
          n_err++;
          $display("FAIL glitch_model g=%0d i=%0d got %0d/%0d/%b/%b want %0d/%0d/%b/%b",
                   g, i, sprite_x, sprite_y, keys_db, frame_tick, rx, ry, rdb, rt);
        end
        if (g > 0) begin
          n_cmp++;
          if (keys_db !== 4'b0000) begin
            n_err++;
            $display("FAIL glitch_db g=%0d len=%0d got %b want 0000", g, len, keys_db);
          end
        end
      end
    end
    n_cmp++;
    if (sprite_x !== PW'(125) || sprite_y !== PW'(112)) begin
      n_err++;
      $display("FAIL glitch_pos got %0d/%0d want 125/112", sprite_x, sprite_y);
    end
  endtask

  task automatic test_clamp(input bit up_left);
    int w, ex, ey;
    reset = 1'b1;
    keys = up_left ? 4'b0101 : 4'b1010;
    vsync = 1'b0;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 130 * 20; i++) begin
      int p, f;
      p = i % 20; f = i / 20;
      if (p == 0) w = $urandom_range(1, 8);
      vsync = (p >= 6 && p < 6 + w);
      @(negedge clk);
      n_cmp++;
      if ({sprite_x, sprite_y, keys_db, frame_tick} !== {rx, ry, rdb, rt}) begin
        n_err++;
        $display("FAIL clamp_model ul=%0d i=%0d got %0d/%0d/%b/%b want %0d/%0d/%b/%b",
                 up_left, i, sprite_x, sprite_y, keys_db, frame_tick, rx, ry, rdb, rt);
      end
      if (p == 19) begin
        ex = up_left ? ((120 - f - 1 < 0) ? 0 : 120 - f - 1) : ((121 + f > 240) ? 240 : 121 + f);
        ey = up_left ? ((112 - f - 1 < 0) ? 0 : 112 - f - 1) : ((113 + f > 224) ? 224 : 113 + f);
        n_cmp++;
        if (sprite_x !== PW'(ex) || sprite_y !== PW'(ey)) begin
          n_err++;
          $display("FAIL clamp_pos ul=%0d frame=%0d got %0d/%0d want %0d/%0d",
                   up_left, f + 1, sprite_x, sprite_y, ex, ey);
        end
      end
    end
  endtask

  task automatic test_reset_tick();
    reset = 1'b1; keys = 4'b0010; vsync = 1'b0;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 80; i++) begin
      int p;
      p = i % 40;
      vsync = (p >= 10 && p < 15);
      reset = (i == 53);
      @(negedge clk);
      n_cmp++;
      if ({sprite_x, sprite_y, keys_db, frame_tick} !== {rx, ry, rdb, rt}) begin
        n_err++;
        $display("FAIL rsttick_model i=%0d got %0d/%0d/%b/%b want %0d/%0d/%b/%b",
                 i, sprite_x, sprite_y, keys_db, frame_tick, rx, ry, rdb, rt);
      end
      if (i == 39 || i == 52) begin
        n_cmp++;
        if (sprite_x !== PW'(121) || (i == 52 && frame_tick !== 1'b1)) begin
          n_err++;
          $display("FAIL rsttick_pre i=%0d got x=%0d t=%b want x=121", i, sprite_x, frame_tick);
        end
      end
      if (i == 53) begin
        n_cmp++;
        if ({sprite_x, keys_db, frame_tick} !== {PW'(120), 4'b0000, 1'b0}) begin
          n_err++;
          $display("FAIL rsttick_post got x=%0d db=%b t=%b want x=120 db=0000 t=0",
                   sprite_x, keys_db, frame_tick);
        end
      end
    end
  endtask

  task automatic test_random();
    int kh_left, vh_left;
    kh_left = 0; vh_left = 0;
    for (int i = 0; i < 1500; i++) begin
      if (kh_left == 0) begin keys = 4'($urandom); kh_left = $urandom_range(1, 12); end
      if (vh_left == 0) begin vsync = ~vsync; vh_left = $urandom_range(1, 15); end
      kh_left--; vh_left--;
      reset = ($urandom_range(0, 299) == 0);
      @(negedge clk);
      n_cmp++;
      if ({sprite_x, sprite_y, keys_db, frame_tick} !== {rx, ry, rdb, rt}) begin
        n_err++;
        $display("FAIL random_model i=%0d got %0d/%0d/%b/%b want %0d/%0d/%b/%b",
                 i, sprite_x, sprite_y, keys_db, frame_tick, rx, ry, rdb, rt);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; keys = '0; vsync = 1'b0;
    test_reset();
    test_move_right();
    test_cancel();
    test_glitch();
    test_clamp(1'b1);
    test_clamp(1'b0);
    test_reset_tick();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/sprite_motion_ctrl.md
Name: sprite_motion_ctrl

Overview:
Upstream control stage for the sprite bitmap display. It takes raw directional keys and the display's vsync, then synchronizes and debounces the keys. Once per frame it moves a sprite position register, clamped to the playfield. The sprite_x/sprite_y outputs feed the sprite renderer's position inputs, and it runs on the same divided pixel clock as the renderer.

Parameters:
- DB_COUNT, 16'd50000: consecutive stable cycles required to accept a key change (bench uses 4).
- POS_W, 9: width of the position outputs.
- X_MIN, 0: minimum sprite x.
- X_MAX, 240: maximum sprite x.
- Y_MIN, 0: minimum sprite y.
- Y_MAX, 224: maximum sprite y.
- X_INIT, 120: reset x.
- Y_INIT, 112: reset y.
- STEP, 1: pixels moved per frame per axis.

Ports:
- clk  in  1: pixel clock (divided clock domain).
- reset  in  1: synchronous, active-high reset.
- keys  in  4: raw asynchronous keys; [0]=left, [1]=right, [2]=up, [3]=down; 1 = pressed.
- vsync  in  1: vertical sync from the renderer; active-high pulse.
- sprite_x  out  POS_W: current sprite x.
- sprite_y  out  POS_W: current sprite y.
- keys_db  out  4: debounced key state, same bit order as keys.
- frame_tick  out  1: one-cycle pulse per frame; the position is updated on the following edge.

Behaviour:
- Reset (synchronous, active-high; clk and reset as named above):
  - sprite_x=X_INIT, sprite_y=Y_INIT, keys_db=0, frame_tick=0.
  - All synchronizer flops, edge-detect flops and debounce counters are 0.
  - Reset asserted mid-operation overrides every update in the same cycle, including a pending frame_tick.
- Synchronizers: keys and vsync each pass through two flops (s1, s2) before any use.
- Debounce, per key, independent:
  - A counter cnt[i] of width ceil(log2(DB_COUNT+1)).
  - If s2[i]==keys_db[i], cnt[i] clears to 0.
  - Otherwise, if cnt[i]==DB_COUNT-1, keys_db[i] takes s2[i] and cnt[i] clears; else cnt[i] increments.
  - A key held steady changes keys_db exactly DB_COUNT+2 edges after the raw change.
  - A glitch shorter than DB_COUNT cycles produces no change.
- Frame tick:
  - A vs_d flop holds the previous vsync s2.
  - frame_tick is registered: frame_tick <= s2_vsync & ~vs_d.
  - It rises 3 edges after vsync rises and lasts exactly 1 cycle, even when vsync is held high for many cycles.
  - No tick is generated on the falling edge of vsync.
- Position update, on the edge where frame_tick==1, using keys_db at that edge:
  - left&~right: if sprite_x >= X_MIN+STEP then sprite_x -= STEP, else sprite_x = X_MIN.
  - right&~left: if sprite_x + STEP <= X_MAX then sprite_x += STEP, else sprite_x = X_MAX.
  - left&right, or neither pressed: sprite_x unchanged.
  - Y axis is identical: up decreases, down increases, with Y_MIN/Y_MAX; up&down means no change.
  - X and Y update in the same cycle; diagonal motion is allowed.
  - Comparisons use POS_W+1 bit arithmetic so there is no wrap-around at 0 or 2^POS_W-1.
  - Position never changes outside frame_tick cycles.
- Constraints:
  - STEP>=1.
  - X_MIN<=X_INIT<=X_MAX and Y_MIN<=Y_INIT<=Y_MAX.
  - X_MAX, Y_MAX < 2^POS_W.
  - DB_COUNT>=1.
- All outputs are registered; no combinational path from any input to any output.

Test Plan (DB_COUNT=4, STEP=1, defaults otherwise):
- Reset for 2 cycles, then idle 20 cycles with keys=0 and vsync=0 -> sprite_x=120, sprite_y=112, keys_db=0, frame_tick never asserted.
- keys=4'b0010 held; vsync pulsed high for 10 cycles once per 100 cycles over 5 frames:
  - keys_db[1] rises exactly 6 edges after the key changes.
  - frame_tick is a single-cycle pulse 3 edges after each vsync rise.
  - sprite_x = 121, 122, …, 125; sprite_y stays 112.
- keys=4'b0011 (left+right) and 4'b1100 (up+down) each held across 3 frames -> position unchanged.
- Key glitches of 1–3 cycles on keys[0] -> keys_db stays 0 and position unchanged.
- Edge clamping:
  - Force a left-up drift from reset over 130 frames -> sprite_x=0 and sprite_y=0 after frame 120/112 and held there, never wrapping to 511.
  - Repeat right-down -> saturates at 240/224.
- Assert reset in the same cycle as frame_tick with right pressed -> next cycle sprite_x=120, keys_db=0, frame_tick=0.
